// File: rtl/pc_seq.sv
// Program-counter sequencer with branch, optional call/return stack and sticky overflow/underflow flags.
// The return-address stack is built only when PC_CALL_STACK_EN is defined; otherwise call acts as branch and ret is ignored.
module pc_seq #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned STEP       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch,
    input  logic                    call,
    input  logic                    ret,
    input  logic [ADDR_W-1:0]       br_address,
    output logic [ADDR_W-1:0]       instr_address,
    output logic [ADDR_W-1:0]       next_seq,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned DEPTH_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    assign next_seq      = pc_q + ADDR_W'(STEP);
    assign instr_address = pc_q;

`ifdef PC_CALL_STACK_EN
    logic [ADDR_W-1:0]  stack_q [DEPTH];
    logic [ADDR_W-1:0]  stack_d [DEPTH];
    logic [PTR_W-1:0]   tos_q;
    logic [PTR_W-1:0]   tos_d;
    logic [PTR_W-1:0]   top_idx;
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               overflow_q;
    logic               overflow_d;
    logic               underflow_q;
    logic               underflow_d;

    // tos_q is the next free slot; when full it also points at the oldest entry
    assign top_idx = tos_q - PTR_W'(1);

    always_comb begin
        pc_d        = pc_q;
        stack_d     = stack_q;
        tos_d       = tos_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (!stall) begin
            if (ret) begin
                if (depth_q != '0) begin
                    pc_d    = stack_q[top_idx];
                    tos_d   = top_idx;
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    pc_d        = next_seq;
                    underflow_d = 1'b1;
                end
            end else if (call) begin
                pc_d           = br_address;
                stack_d[tos_q] = next_seq;
                tos_d          = tos_q + PTR_W'(1);
                if (depth_q == DEPTH_W'(DEPTH)) begin
                    overflow_d = 1'b1;
                end else begin
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end else if (branch) begin
                pc_d = br_address;
            end else begin
                pc_d = next_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= ADDR_W'(RESET_ADDR);
            tos_q       <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            tos_q       <= tos_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack storage carries no reset; its contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            stack_q <= stack_d;
        end
    end

    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_ret;

    assign unused_ret = ret;

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (call || branch) begin
                pc_d = br_address;
            end else begin
                pc_d = next_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= ADDR_W'(RESET_ADDR);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign depth     = '0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq (ADDR_W=10, DEPTH=4); expectations follow whether PC_CALL_STACK_EN is defined.
module tb_pc_seq;

`ifdef PC_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       stall;
    logic       branch;
    logic       call;
    logic       ret;
    logic [9:0] br_address;
    logic [9:0] instr_address;
    logic [9:0] next_seq;
    logic [2:0] depth;
    logic       overflow;
    logic       underflow;

    int tests_run;
    int tests_failed;

    pc_seq #(
        .ADDR_W     (10),
        .DEPTH      (4),
        .RESET_ADDR (0),
        .STEP       (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .call          (call),
        .ret           (ret),
        .br_address    (br_address),
        .instr_address (instr_address),
        .next_seq      (next_seq),
        .depth         (depth),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pick the expectation for the configured build
    function automatic logic [31:0] sel(input logic [31:0] with_stk, input logic [31:0] no_stk);
        return STK ? with_stk : no_stk;
    endfunction

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] dep,
                               input logic [31:0] ovf, input logic [31:0] unf);
        check({tag, ".pc"},  32'(instr_address), pc);
        check({tag, ".dep"}, 32'(depth), dep);
        check({tag, ".ovf"}, 32'(overflow), ovf);
        check({tag, ".unf"}, 32'(underflow), unf);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        branch     = 1'b1;
        call       = 1'b0;
        ret        = 1'b0;
        br_address = 10'h003;

        // Reset dominates a held branch
        tick();
        check_state("rst0", 32'h000, 0, 0, 0);
        tick();
        check("rst1.pc", 32'(instr_address), 32'h000);
        reset = 1'b0;
        tick();
        check("br_after_rst", 32'(instr_address), 32'h003);
        branch = 1'b0;
        tick();
        check("seq1", 32'(instr_address), 32'h004);
        tick();
        check("seq2", 32'(instr_address), 32'h005);
        check("next_seq", 32'(next_seq), 32'h006);
        tick();
        check("seq3", 32'(instr_address), 32'h006);

        // Stall freezes the PC even with branch pending
        stall = 1'b1; branch = 1'b1; br_address = 10'h002;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 32'(instr_address), 32'h006);
        end
        stall = 1'b0;
        tick();
        check("br_after_stall", 32'(instr_address), 32'h002);

        // Single call then return
        br_address = 10'h010;
        tick();
        check("br_010", 32'(instr_address), 32'h010);
        branch = 1'b0; call = 1'b1; br_address = 10'h100;
        tick();
        check_state("call1", 32'h100, sel(1, 0), 0, 0);
        call = 1'b0; ret = 1'b1;
        tick();
        check_state("ret1", sel(32'h011, 32'h101), 0, 0, 0);
        ret = 1'b0;

        // Five calls overflow the four-entry stack
        branch = 1'b1; br_address = 10'h020;
        tick();
        check("br_020", 32'(instr_address), 32'h020);
        branch = 1'b0; call = 1'b1; br_address = 10'h200;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("ovf_call.pc", 32'(instr_address), 32'h200);
            check("ovf_call.dep", 32'(depth), sel((i > 4) ? 4 : i, 0));
            check("ovf_call.ovf", 32'(overflow), sel((i > 4) ? 1 : 0, 0));
        end
        call = 1'b0; ret = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("pop.pc", 32'(instr_address), sel(32'h201, 32'(32'h200 + i)));
            check("pop.dep", 32'(depth), sel(4 - i, 0));
        end
        tick();
        check_state("ret_empty", sel(32'h202, 32'h205), 0, sel(1, 0), sel(1, 0));
        ret = 1'b0;

        // Address wrap and call from the last address
        branch = 1'b1; br_address = 10'h3FF;
        tick();
        check("br_3ff", 32'(instr_address), 32'h3FF);
        check("next_seq_wrap", 32'(next_seq), 32'h000);
        branch = 1'b0;
        tick();
        check("wrap", 32'(instr_address), 32'h000);
        branch = 1'b1;
        tick();
        branch = 1'b0; call = 1'b1; br_address = 10'h050;
        tick();
        check_state("call_3ff", 32'h050, sel(1, 0), sel(1, 0), sel(1, 0));
        call = 1'b0; ret = 1'b1;
        tick();
        check_state("ret_wrap", sel(32'h000, 32'h051), 0, sel(1, 0), sel(1, 0));
        ret = 1'b0;

        // Call and ret together: ret wins, nothing is pushed
        branch = 1'b1; br_address = 10'h03F;
        tick();
        branch = 1'b0; call = 1'b1; br_address = 10'h123;
        tick();
        check_state("call_03f", 32'h123, sel(1, 0), sel(1, 0), sel(1, 0));
        ret = 1'b1; br_address = 10'h300;
        tick();
        check_state("call_ret", sel(32'h040, 32'h300), 0, sel(1, 0), sel(1, 0));
        call = 1'b0;
        tick();
        check_state("ret_after", sel(32'h041, 32'h301), 0, sel(1, 0), sel(1, 0));

        // Stall keeps sticky flags and depth
        ret = 1'b0; stall = 1'b1; call = 1'b1;
        tick();
        check_state("stall_flags", sel(32'h041, 32'h301), 0, sel(1, 0), sel(1, 0));

        // Reset with stall/call/ret high clears everything
        reset = 1'b1; ret = 1'b1;
        tick();
        check_state("rst_mid", 32'h000, 0, 0, 0);
        reset = 1'b0; stall = 1'b0; call = 1'b0; ret = 1'b0; branch = 1'b0;
        tick();
        check("seq_after_rst", 32'(instr_address), 32'h001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, program-counter and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_ADDR, default 0, value loaded into instr_address on reset.
REQ-004 SHALL have parameter STEP, default 1, sequential increment.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port stall  input  1  freezes all state.
REQ-007 SHALL have port branch  input  1  load br_address.
REQ-008 SHALL have port call  input  1  push return address and load br_address.
REQ-009 SHALL have port ret  input  1  pop return address into PC.
REQ-010 SHALL have port br_address  input  ADDR_W  branch/call target.
REQ-011 SHALL have port instr_address  output  ADDR_W  current fetch address (registered).
REQ-012 SHALL have port next_seq  output  ADDR_W  instr_address+STEP (combinational).
REQ-013 SHALL have port depth  output  $clog2(DEPTH)+1  valid stack entries.
REQ-014 SHALL have port overflow  output  1  sticky; call while full.
REQ-015 SHALL have port underflow  output  1  sticky; ret while empty.

Function
REQ-016 SHALL sample controls on rising clk; instr_address changes one cycle after the controlling input (latency 1).
REQ-017 SHALL apply priority per cycle: reset > stall > ret > call > branch > sequential.
REQ-018 SHALL, on stall, hold instr_address, stack, depth and flags; all other controls ignored that cycle.
REQ-019 SHALL, on sequential cycle, load next_seq; arithmetic modulo 2^ADDR_W (0x3FF+1 -> 0x000 at ADDR_W=10).
REQ-020 SHALL, on branch, load br_address; stack untouched.
REQ-021 SHALL, on call, push next_seq, load br_address, depth+1.
REQ-022 SHALL, on call with depth==DEPTH, overwrite oldest entry (circular), keep depth==DEPTH, set overflow.
REQ-023 SHALL, on ret with depth>0, load top entry, depth-1.
REQ-024 SHALL, on ret with depth==0, behave as sequential cycle and set underflow.
REQ-025 SHALL, on ret and call in the same cycle, perform ret only; call and branch ignored.
REQ-026 SHALL keep overflow/underflow set until reset.

Reset
REQ-027 SHALL, on reset, set instr_address=RESET_ADDR, depth=0, overflow=0, underflow=0; stack contents don't-care.
REQ-028 SHALL, on reset asserted mid-operation (including with stall/call/ret high), apply REQ-027 at that edge and discard the pending operation.

Configuration
REQ-029 SHALL include the return-address stack only when PC_CALL_STACK_EN is defined.
REQ-030 SHALL, without PC_CALL_STACK_EN, treat call as branch, ignore ret (sequential cycle), tie depth, overflow, underflow to 0, and instantiate no stack storage.

Verification (ADDR_W=10, DEPTH=4, RESET_ADDR=0, STEP=1, PC_CALL_STACK_EN defined)
REQ-031 SHALL cover: reset 2 cycles with branch=1, br_address=0x003 -> instr_address 0x000 during reset; reset released, branch held -> 0x003, branch dropped -> 0x004, 0x005.
REQ-032 SHALL cover: stall=1 three cycles at 0x006 with branch=1, br_address=0x002 -> holds 0x006; stall released, branch still 1 -> 0x002.
REQ-033 SHALL cover: call at 0x010, target 0x100 -> 0x100, depth=1; ret next cycle -> 0x011, depth=0.
REQ-034 SHALL cover: 5 consecutive calls to 0x200 from 0x020 -> overflow=1, depth=4; 4 rets -> 0x201,0x201,0x201,0x201 popped, depth 0; 5th ret -> sequential, underflow=1.
REQ-035 SHALL cover: branch to 0x3FF -> next cycle 0x000 (wrap); call at 0x3FF target 0x050 then ret -> 0x000.
REQ-036 SHALL cover: call and ret same cycle with depth=1 holding 0x040 -> 0x040, depth=0, no push.
